// File: rtl/posit_pkg.sv
// Shared posit definitions used by the decoder and the posit adder.
package posit_pkg;

  localparam int POSIT_N  = 32;
  localparam int POSIT_ES = 2;
  localparam int SCALE_W  = 8;
  localparam int FRAC_W   = POSIT_N - 4;
  localparam int RUN_W    = $clog2(POSIT_N);

  // Decoded posit: frac carries the hidden 1 in its MSB.
  typedef struct packed {
    logic               sign;
    logic [SCALE_W-1:0] scale;
    logic [FRAC_W-1:0]  frac;
    logic               zero;
    logic               inf;
  } posit_t;

endpackage

// File: rtl/posit_lzc.sv
// Leading-run counter: number of bits from the MSB down that equal the MSB.
module posit_lzc
  import posit_pkg::*;
#(
  parameter int W  = POSIT_N - 1,
  parameter int CW = RUN_W
) (
  input  logic [W-1:0]  i_bits,
  output logic [CW-1:0] o_run
);

  logic [CW-1:0] w_cnt;
  logic          w_stop;

  // Walk down from the MSB, counting until the first bit that differs.
  always_comb begin
    w_cnt  = CW'(1);
    w_stop = 1'b0;
    for (int i = W - 2; i >= 0; i--) begin
      if (!w_stop) begin
        if (i_bits[i] == i_bits[W-1]) w_cnt = w_cnt + CW'(1);
        else                          w_stop = 1'b1;
      end
    end
  end

  assign o_run = w_cnt;

endmodule

// File: rtl/posit_decode.sv
// Two-stage posit decoder: S1 takes magnitude and flags, S2 splits
// regime / exponent / fraction into sign, scale and hidden-bit significand.
module posit_decode
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int ES = POSIT_ES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [N-1:0]       in_data,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign,
  output logic [SCALE_W-1:0] out_scale,
  output logic [N-5:0]       out_frac,
  output logic               out_zero,
  output logic               out_inf
);

  logic           r_v1, r_v2;
  logic           r_s1_sign, r_s1_zero, r_s1_inf;
  logic [N-2:0]   r_s1_abs;
  posit_t         r_s2;
  posit_t         w_dec;

  logic           w_s2_en;
  logic [RUN_W-1:0] w_run;
  logic [RUN_W:0] w_shamt;
  logic [N-2:0]   w_body;
  logic [SCALE_W-1:0] w_k;
  logic           w_unused_ok;

  // S2 moves when empty or being drained; S1 moves when empty or S2 moves.
  assign w_s2_en  = !r_v2 || out_ready;
  assign in_ready = rst_n && (!r_v1 || w_s2_en);

  // S1: flags and magnitude; only the low N-1 bits of the magnitude matter
  // because the NaR case (the one with bit N-1 set) is handled by its flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1      <= 1'b0;
      r_s1_sign <= 1'b0;
      r_s1_zero <= 1'b0;
      r_s1_inf  <= 1'b0;
      r_s1_abs  <= '0;
    end else if (in_ready) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_s1_sign <= in_data[N-1];
        r_s1_zero <= (in_data == '0);
        r_s1_inf  <= (in_data == {1'b1, {(N-1){1'b0}}});
        r_s1_abs  <= in_data[N-1] ? (~in_data[N-2:0] + 1'b1) : in_data[N-2:0];
      end
    end
  end

  posit_lzc #(.W(N - 1), .CW(RUN_W)) u_lzc (
    .i_bits (r_s1_abs),
    .o_run  (w_run)
  );

  // Shifting out regime plus terminator left-aligns exponent then fraction;
  // a run reaching bit 0 shifts everything out, leaving zeros.
  assign w_shamt = {1'b0, w_run} + (RUN_W + 1)'(1);
  assign w_body  = r_s1_abs << w_shamt;
  assign w_unused_ok = ^w_body[3-ES:0];

  // Field assembly; zero and NaR force all numeric fields to zero.
  always_comb begin
    w_dec = '0;
    w_k   = r_s1_abs[N-2] ? (SCALE_W'(w_run) - SCALE_W'(1)) : (-SCALE_W'(w_run));
    if (!(r_s1_zero || r_s1_inf)) begin
      w_dec.sign  = r_s1_sign;
      w_dec.scale = (w_k << ES) + SCALE_W'(w_body[N-2 -: ES]);
      w_dec.frac  = {1'b1, w_body[N-2-ES -: N-5]};
    end
    w_dec.zero = r_s1_zero;
    w_dec.inf  = r_s1_inf;
  end

  // S2: output register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v2 <= 1'b0;
      r_s2 <= '0;
    end else if (w_s2_en) begin
      r_v2 <= r_v1;
      if (r_v1) r_s2 <= w_dec;
    end
  end

  assign out_valid = r_v2;
  assign out_sign  = r_s2.sign;
  assign out_scale = r_s2.scale;
  assign out_frac  = r_s2.frac;
  assign out_zero  = r_s2.zero;
  assign out_inf   = r_s2.inf;

endmodule

// File: tb/tb_posit_decode.sv
// Bench for posit_decode: directed vectors, stall, reset and random stream.
module tb_posit_decode;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid, out_sign, out_zero, out_inf;
  logic [7:0]  out_scale;
  logic [27:0] out_frac;
  logic [38:0] obs;

  int n_chk = 0;
  int n_fail = 0;

  posit_decode #(.N(32), .ES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_scale(out_scale), .out_frac(out_frac),
    .out_zero(out_zero), .out_inf(out_inf)
  );

  always #5 clk = ~clk;

  assign obs = {out_sign, out_scale, out_frac, out_zero, out_inf};

  function automatic int bit_at(input logic [31:0] v, input int i);
    if (i < 0) return 0;
    return v[i] ? 1 : 0;
  endfunction

  // Reference: walk the magnitude bit by bit from bit 30 downwards.
  function automatic logic [38:0] ref_dec(input logic [31:0] x);
    logic [31:0] v;
    logic        first;
    int i, m, k, e, f;
    if (x == 32'h0)         return {1'b0, 8'h0, 28'h0, 1'b1, 1'b0};
    if (x == 32'h8000_0000) return {1'b0, 8'h0, 28'h0, 1'b0, 1'b1};
    v = x[31] ? (~x + 32'd1) : x;
    first = v[30];
    m = 0;
    i = 30;
    while (i >= 0) begin
      if (v[i] != first) break;
      m++;
      i--;
    end
    k = first ? m - 1 : -m;
    i--;
    e = 0;
    repeat (2) begin e = e * 2 + bit_at(v, i); i--; end
    f = 1;
    repeat (27) begin f = f * 2 + bit_at(v, i); i--; end
    return {x[31], 8'(4 * k + e), 28'(f), 1'b0, 1'b0};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] x;
    case ($urandom_range(0, 9))
      0: begin
        case ($urandom_range(0, 5))
          0: x = 32'h0000_0000;
          1: x = 32'h8000_0000;
          2: x = 32'h0000_0001;
          3: x = 32'h7FFF_FFFF;
          4: x = 32'hFFFF_FFFF;
          default: x = 32'h8000_0001;
        endcase
      end
      1, 2: begin
        x = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) x = ~x;
      end
      default: x = $urandom;
    endcase
    return x;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_chk++; if (obs !== 39'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", obs); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_directed(input logic [31:0] x, input logic [38:0] exp, input string name);
    @(negedge clk);
    in_valid = 1'b1; in_data = x; out_ready = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready: got %b expected 1", name, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_early: out_valid got %b expected 0", name, out_valid); end
    @(negedge clk);
    #1;
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s_latency: out_valid got %b expected 1", name, out_valid); end
    n_chk++; if (obs !== exp) begin n_fail++; $display("FAIL %s_fields: got %h expected %h", name, obs, exp); end
  endtask

  task automatic test_stall();
    logic [31:0] w [3];
    logic [38:0] e [3];
    int idx, n;
    w[0] = 32'h4000_0000; w[1] = 32'h4800_0000; w[2] = 32'h0000_0001;
    e[0] = {1'b0, 8'h00, 28'h800_0000, 2'b00};
    e[1] = {1'b0, 8'h01, 28'h800_0000, 2'b00};
    e[2] = {1'b0, 8'h88, 28'h800_0000, 2'b00};
    idx = 0; n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      out_ready = (c >= 4);
      in_valid  = (idx < 3);
      in_data   = (idx < 3) ? w[idx] : 32'h0;
      #1;
      if (c < 2) begin
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_c%0d: got %b expected 1", c, in_ready); end
      end
      if (c == 2 || c == 3) begin
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_drop_c%0d: got %b expected 0", c, in_ready); end
      end
      if (out_valid && out_ready) begin
        n_chk++;
        if (n >= 3) begin n_fail++; $display("FAIL stall_extra: got %h expected no word", obs); end
        else if (obs !== e[n]) begin n_fail++; $display("FAIL stall_word%0d: got %h expected %h", n, obs, e[n]); end
        n++;
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0;
    n_chk++; if (n != 3) begin n_fail++; $display("FAIL stall_count: got %0d expected 3", n); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h4000_0000;
    @(negedge clk);
    in_data = 32'h4800_0000;
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready_low: got %b expected 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
    n_chk++; if (obs !== 39'h0) begin n_fail++; $display("FAIL rstmid_data: got %h expected 0", obs); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 1", in_ready); end
    out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      #1;
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_ghost: out_valid got %b expected 0", out_valid); end
    end
  endtask

  task automatic test_random();
    logic [38:0] q[$];
    logic [38:0] hold_val, exp;
    logic        hold_v;
    int sent, cycles;
    sent = 0; cycles = 0; hold_v = 1'b0; hold_val = '0;
    while ((sent < 10000 || q.size() > 0) && cycles < 60000) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (sent < 10000) && ($urandom_range(0, 4) != 0);
      in_data   = rand_word();
      #1;
      if (hold_v) begin
        n_chk++;
        if (out_valid !== 1'b1 || obs !== hold_val) begin
          n_fail++; $display("FAIL rand_hold: got v=%b %h expected v=1 %h", out_valid, obs, hold_val);
        end
      end
      if (out_valid && out_ready) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rand_spurious: got %h expected no word", obs);
        end else begin
          exp = q.pop_front();
          if (obs !== exp) begin n_fail++; $display("FAIL rand_word: got %h expected %h", obs, exp); end
        end
      end
      hold_v   = out_valid && !out_ready;
      hold_val = obs;
      if (in_valid && in_ready) begin
        q.push_back(ref_dec(in_data));
        sent++;
      end
      cycles++;
    end
    in_valid = 1'b0;
    n_chk++;
    if (cycles >= 60000) begin
      n_fail++; $display("FAIL rand_timeout: got %0d sent, %0d pending expected drain", sent, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed(32'h4000_0000, {1'b0, 8'h00, 28'h800_0000, 2'b00}, "one");
    test_directed(32'h4800_0000, {1'b0, 8'h01, 28'h800_0000, 2'b00}, "two");
    test_directed(32'hC000_0000, {1'b1, 8'h00, 28'h800_0000, 2'b00}, "neg_one");
    test_directed(32'h0000_0001, {1'b0, 8'h88, 28'h800_0000, 2'b00}, "minpos");
    test_directed(32'h7FFF_FFFF, {1'b0, 8'h78, 28'h800_0000, 2'b00}, "maxpos");
    test_directed(32'h0000_0000, {1'b0, 8'h00, 28'h000_0000, 2'b10}, "zero");
    test_directed(32'h8000_0000, {1'b0, 8'h00, 28'h000_0000, 2'b01}, "nar");
    test_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/posit_decode.md
POSIT_DECODE -- requirements
Module: posit_decode

Interface
REQ-001 Parameter N, 32: posit word width.
REQ-002 Parameter ES, 2: exponent field width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 in_valid  in  1  in_data carries a posit this cycle.
REQ-006 in_data  in  N  raw posit word.
REQ-007 in_ready  out  1  block accepts in_data this cycle.
REQ-008 out_valid  out  1  decoded fields valid.
REQ-009 out_ready  in  1  downstream adder accepts output.
REQ-010 out_sign  out  1  sign of value.
REQ-011 out_scale  out  8  signed scale, 2^ES*k + e.
REQ-012 out_frac  out  N-4  significand, hidden bit at MSB, left-aligned.
REQ-013 out_zero  out  1  input was 0x00000000.
REQ-014 out_inf  out  1  input was NaR (0x80000000).

Function
REQ-015 Transfer occurs on a cycle where valid and ready are both high, at each port.
REQ-016 Two-stage pipeline: S1 registers the sign, zero/inf flags and the absolute value (two's complement if sign set); S2 registers the decoded fields.
REQ-017 Latency: input accepted at cycle t SHALL appear on the outputs at cycle t+2 when out_ready is held high.
REQ-018 Throughput: one word per cycle when out_ready is high.
REQ-019 Each stage SHALL advance when it is empty or the next stage advances; in_ready = S1 empty or S1 advancing.
REQ-020 While out_valid is high and out_ready is low, all out_* SHALL hold stable.
REQ-021 Regime: run length m of identical bits starting at bit N-2; leading 1s give k=m-1; leading 0s give k=-m.
REQ-022 Exponent: the ES bits after the regime terminator; bits truncated past bit 0 read as 0.
REQ-023 Fraction: the remaining bits, left-aligned below the hidden 1; missing bits zero-filled.
REQ-024 Scale range -120..+120 for N=32, ES=2; no saturation logic is needed.
REQ-025 Zero or NaR: out_sign=0, out_scale=0, out_frac=0; only the matching flag is set.
REQ-026 A regime run that reaches bit 0 (no terminator) is legal; exponent=0 and fraction=hidden bit only.
REQ-027 Simultaneous accept and emit in the same cycle SHALL neither drop nor duplicate a word.

Reset
REQ-028 While rst_n is low at a clock edge, both stages SHALL be cleared to empty: out_valid=0, in_ready=0, and all data outputs=0.
REQ-029 in_ready SHALL go high on the first cycle after rst_n returns high.
REQ-030 Reset asserted mid-stream SHALL discard all in-flight words; none SHALL appear after reset.

Structure
REQ-031 N, ES, the scale width, the fraction width and a packed decoded-posit struct (sign, scale, frac, zero, inf) SHALL reside in shared package posit_pkg, which positadd also uses.
REQ-032 Regime run-length counting SHALL be a combinational sub-module, posit_lzc (leading-run count over N-1 bits, 5-bit result).

Verification
REQ-033 0x40000000 -> sign 0, scale 0, frac 0x8000000, flags 0, output two cycles after accept.
REQ-034 0x48000000 -> scale 1, frac 0x8000000; 0xC0000000 -> sign 1, scale 0, frac 0x8000000.
REQ-035 0x00000001 -> scale -120, frac 0x8000000; 0x7FFFFFFF -> scale +120; 0x00000000 -> zero=1; 0x80000000 -> inf=1.
REQ-036 Stream of 0x40000000, 0x48000000, 0x00000001 with out_ready held low for 4 cycles -> in_ready drops after the second word; all three emerge in order with no loss once out_ready rises.
REQ-037 rst_n pulled low for 1 cycle with 2 words in flight -> out_valid=0 the next cycle; neither word is ever emitted.
REQ-038 Random 10k words against a reference decoder model -> all fields match bit-exactly, including under random out_ready toggling.
